cic_decimator_mc: RTL

- Multi-channel, runtime-ratio CIC decimator; next-generation replacement for the fixed R=8, single-channel first decimation stage.
- NUM_CH parallel channels share one decimation counter; ratio 2^k is selectable at run time.
- Output is gain-normalised, rounded and saturated, then serialised one channel per beat over a valid/ready interface toward the FIR compensation stage.

---
 rtl/cic_decimator_mc.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: run-time ratio 2^k, gain-normalised output serialised one channel per beat.
// Build option CIC_ROUND_EN: round-half-up with positive saturation; otherwise plain truncation.
module cic_decimator_mc #(
    parameter int NUM_CH       = 2,
    parameter int INPUT_WIDTH  = 5,
    parameter int N            = 5,
    parameter int KMAX         = 4,
    parameter int OUTPUT_WIDTH = 24,
    localparam int W  = INPUT_WIDTH + N * KMAX,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int KW = $clog2(KMAX + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [NUM_CH*INPUT_WIDTH-1:0]  in_data,
    input  logic [KW-1:0]                  dec_log2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CW-1:0]                  out_ch,
    output logic [OUTPUT_WIDTH-1:0]        out_data,
    output logic                           settled,
    output logic                           overrun
);
    localparam int FW = $clog2(N + 1);

    typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic [KW-1:0]           k_q;
    logic [KMAX-1:0]         cnt_q;
    logic [W-1:0]            integ_q [NUM_CH][N];
    logic [W-1:0]            integ_d [NUM_CH][N];
    logic [W-1:0]            cin_q   [NUM_CH];
    logic [W-1:0]            dly_q   [NUM_CH][N];
    logic [W-1:0]            dly_d   [NUM_CH][N];
    logic [OUTPUT_WIDTH-1:0] norm_s  [NUM_CH];
    logic [OUTPUT_WIDTH-1:0] buf_q   [NUM_CH];
    logic                    go_q, emit_q;
    logic                    out_valid_q, overrun_q, settled_s;
    logic [CW-1:0]           out_ch_q;
    logic [OUTPUT_WIDTH-1:0] out_data_q;
    logic [KMAX-1:0]         frame_last_s;
    logic [7:0]              sh_s;
    logic                    boundary_s, dec_ok_s, change_s, accept_s, last_s, free_s;

    function automatic logic [OUTPUT_WIDTH-1:0] norm_f(input logic [W-1:0] v);
`ifdef CIC_ROUND_EN
        localparam int RSH = (W > OUTPUT_WIDTH) ? (W - OUTPUT_WIDTH - 1) : 0;
        localparam logic [W-1:0] HALF = (W > OUTPUT_WIDTH) ? (W'(1) << RSH) : '0;
        localparam logic [OUTPUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        logic [W-1:0] rnd;
        rnd = v + HALF;
        if (!v[W-1] && rnd[W-1]) begin
            return POS_MAX;
        end else begin
            return rnd[W-1 -: OUTPUT_WIDTH];
        end
`else
        return v[W-1 -: OUTPUT_WIDTH];
`endif
    endfunction

    // Frame boundary, ratio-change and output handshake decode
    always_comb begin
        frame_last_s = {KMAX{1'b1}} >> (KW'(KMAX) - k_q);
        boundary_s   = in_valid && (cnt_q == frame_last_s);
        dec_ok_s     = (dec_log2 >= KW'(1)) && (dec_log2 <= KW'(KMAX));
        change_s     = boundary_s && dec_ok_s && (dec_log2 != k_q);
        accept_s     = out_valid_q && out_ready;
        last_s       = accept_s && (out_ch_q == CW'(NUM_CH - 1));
        free_s       = !out_valid_q || last_s;
    end

    // Integrator cascade, comb cascade and normalisation per channel
    always_comb begin
        logic [W-1:0] acc;
        acc  = '0;
        sh_s = 8'(N) * (8'(KMAX) - 8'(k_q));
        for (int c = 0; c < NUM_CH; c++) begin
            acc = {{(W-INPUT_WIDTH){in_data[c*INPUT_WIDTH+INPUT_WIDTH-1]}},
                   in_data[c*INPUT_WIDTH +: INPUT_WIDTH]};
            for (int s = 0; s < N; s++) begin
                integ_d[c][s] = integ_q[c][s] + acc;
                acc           = integ_d[c][s];
            end
            acc = cin_q[c];
            for (int s = 0; s < N; s++) begin
                dly_d[c][s] = acc;
                acc         = acc - dly_q[c][s];
            end
            norm_s[c] = norm_f(acc << sh_s);
        end
    end

    // Datapath state: integrators, decimation counter, comb pipeline, active ratio
    always_ff @(posedge clk or posedge rst) begin
        if (rst || change_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cin_q[c] <= '0;
                for (int s = 0; s < N; s++) begin
                    integ_q[c][s] <= '0;
                    dly_q[c][s]   <= '0;
                end
            end
            cnt_q  <= '0;
            go_q   <= 1'b0;
            emit_q <= 1'b0;
            k_q    <= rst ? KW'(KMAX) : dec_log2;
        end else begin
            if (in_valid) begin
                integ_q <= integ_d;
                cnt_q   <= boundary_s ? '0 : cnt_q + KMAX'(1);
            end else begin
                cnt_q <= cnt_q;
            end
            go_q   <= boundary_s;
            emit_q <= boundary_s && (state_q == RUN);
            if (boundary_s) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cin_q[c] <= integ_d[c][N-1];
                end
            end
            if (go_q) begin
                dly_q <= dly_d;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // FSM next state: discard N frames after reset or ratio change
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (change_s) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (boundary_s) begin
            case (state_q)
                FILL: begin
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FW'(N - 1)) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = FILL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs
    always_comb begin
        settled_s = (state_q == RUN);
    end

    // Output buffer and serialiser; a full buffer drops the incoming frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                buf_q[c] <= '0;
            end
        end else begin
            if (emit_q && free_s) begin
                buf_q       <= norm_s;
                out_data_q  <= norm_s[0];
                out_ch_q    <= '0;
                out_valid_q <= 1'b1;
            end else if (accept_s) begin
                if (last_s) begin
                    out_valid_q <= 1'b0;
                    out_ch_q    <= '0;
                end else begin
                    out_ch_q   <= out_ch_q + CW'(1);
                    out_data_q <= buf_q[out_ch_q + CW'(1)];
                end
            end
            if (emit_q && !free_s) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign settled   = settled_s;
    assign overrun   = overrun_q;
endmodule
